// File: rtl/wb_master_pkg.sv
// Shared definitions for the Wishbone classic single-transaction master.
//
// Contents:
//   WB_AW / WB_DW / WB_SW : address, data and byte-select widths
//   wbm_state_e           : bridge FSM states (IDLE, BUS, RESP)
//   WBM_OK/ERR/TIMEOUT    : rsp_status_o encodings (2'b11 is never produced)
package wb_master_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;
    localparam int WB_SW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wbm_state_e;

    localparam logic [1:0] WBM_OK      = 2'b00;
    localparam logic [1:0] WBM_ERR     = 2'b01;
    localparam logic [1:0] WBM_TIMEOUT = 2'b10;

endpackage

// File: rtl/wb_timeout_counter.sv
// Saturating wait counter for the Wishbone master bridge.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : zero the count (command accepted)
//   en         : a strobe cycle is in progress this cycle
//   expired    : this strobe cycle is the LIMIT-th one since clr
//
// The count holds the number of strobe cycles already completed, so during
// the k-th strobe cycle it reads k-1. Flagging at LIMIT-1 therefore keeps
// stb high for exactly LIMIT cycles before the abort takes effect.
// Only built when WB_MASTER_TIMEOUT_EN is defined.
module wb_timeout_counter #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);
    localparam logic [W-1:0] MAX  = '1;

    logic [W-1:0] count;

    // Saturates at all-ones; MAX >= LIMIT so the flag can never be missed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != MAX)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = en && (count >= LAST);

endmodule

// File: rtl/wb_master_bridge.sv
// Wishbone B4 classic (non-pipelined) single-transaction initiator.
// Converts one valid/ready command into one Wishbone cycle and returns a
// status/data response. At most one transaction is outstanding.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid is never withdrawn by this block once raised, and the
// payload stays stable until the transfer.
//
// Ports:
//   wb_clk_i, wb_rst_n_i          : clock, async active-low reset
//   cmd_valid/ready, cmd_we/sel/adr/dat : command stream in
//   rsp_valid/ready, rsp_dat/status     : response stream out
//   wbm_cyc/stb/we/sel/adr/dat_o  : Wishbone master outputs
//   wbm_ack/err/dat_i             : Wishbone slave response
//   dbg_state_o                   : current FSM state (wbm_state_e encoding)
//
// Build option: WB_MASTER_TIMEOUT_EN adds a strobe watchdog that aborts the
// cycle after TIMEOUT_CYCLES strobe cycles with status WBM_TIMEOUT. Without
// it the bridge waits indefinitely and TIMEOUT_CYCLES has no effect.
module wb_master_bridge
    import wb_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [WB_SW-1:0] cmd_sel_i,
    input  logic [WB_AW-1:0] cmd_adr_i,
    input  logic [WB_DW-1:0] cmd_dat_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WB_DW-1:0] rsp_dat_o,
    output logic [1:0]       rsp_status_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [WB_SW-1:0] wbm_sel_o,
    output logic [WB_AW-1:0] wbm_adr_o,
    output logic [WB_DW-1:0] wbm_dat_o,
    input  logic             wbm_ack_i,
    input  logic             wbm_err_i,
    input  logic [WB_DW-1:0] wbm_dat_i,
    output logic [1:0]       dbg_state_o
);

    wbm_state_e state;
    logic       cmd_take;

    // cmd_ready_o is a registered copy of (state == IDLE).
    assign cmd_take    = cmd_ready_o && cmd_valid_i;
    assign dbg_state_o = state;

`ifdef WB_MASTER_TIMEOUT_EN
    logic expired;

    wb_timeout_counter #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_n_i),
        .clr    (cmd_take),
        .en     (state == BUS),
        .expired(expired)
    );
`else
    // Without the watchdog the parameter is accepted but has no effect.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state        <= IDLE;
            cmd_ready_o  <= 1'b1;
            rsp_valid_o  <= 1'b0;
            rsp_dat_o    <= '0;
            rsp_status_o <= WBM_OK;
            wbm_cyc_o    <= 1'b0;
            wbm_stb_o    <= 1'b0;
            wbm_we_o     <= 1'b0;
            wbm_sel_o    <= '0;
            wbm_adr_o    <= '0;
            wbm_dat_o    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_take) begin
                        wbm_we_o    <= cmd_we_i;
                        wbm_sel_o   <= cmd_sel_i;
                        wbm_adr_o   <= cmd_adr_i;
                        wbm_dat_o   <= cmd_dat_i;
                        wbm_cyc_o   <= 1'b1;
                        wbm_stb_o   <= 1'b1;
                        cmd_ready_o <= 1'b0;
                        state       <= BUS;
                    end
                end

                BUS: begin
                    // err has priority over ack; a slave response in the
                    // limit cycle has priority over the watchdog.
                    if (wbm_err_i || wbm_ack_i
`ifdef WB_MASTER_TIMEOUT_EN
                        || expired
`endif
                    ) begin
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        state       <= RESP;
                        if (wbm_err_i) begin
                            rsp_status_o <= WBM_ERR;
                            rsp_dat_o    <= '0;
                        end else if (wbm_ack_i) begin
                            rsp_status_o <= WBM_OK;
                            rsp_dat_o    <= wbm_we_o ? '0 : wbm_dat_i;
                        end else begin
`ifdef WB_MASTER_TIMEOUT_EN
                            rsp_status_o <= WBM_TIMEOUT;
`else
                            rsp_status_o <= WBM_ERR;
`endif
                            rsp_dat_o    <= '0;
                        end
                    end
                end

                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: begin
                    state       <= IDLE;
                    cmd_ready_o <= 1'b1;
                    rsp_valid_o <= 1'b0;
                    wbm_cyc_o   <= 1'b0;
                    wbm_stb_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Self-checking bench for wb_master_bridge: directed plan items followed by
// randomized transactions, scored against a transaction-level model.
module tb_wb_master_bridge;

    localparam int TIMEOUT = 8;
    localparam int N_TXN   = 30;
    localparam int K_ACK   = 0;
    localparam int K_ERR   = 1;
    localparam int K_BOTH  = 2;
    localparam int K_NONE  = 3;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [3:0]  cmd_sel_i;
    logic [31:0] cmd_adr_i;
    logic [31:0] cmd_dat_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_dat_o;
    logic [1:0]  rsp_status_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic        wbm_err_i;
    logic [31:0] wbm_dat_i;
    logic [1:0]  dbg_state_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [33:0] exp_q[$];

    logic        t_we[N_TXN];
    logic [3:0]  t_sel[N_TXN];
    logic [31:0] t_adr[N_TXN];
    logic [31:0] t_dat[N_TXN];
    logic [31:0] t_rd[N_TXN];
    int          t_waits[N_TXN];
    int          t_kind[N_TXN];
    int          t_hold[N_TXN];
    logic        t_chain[N_TXN];

    wb_master_bridge #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_n_i  (wb_rst_n_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_we_i    (cmd_we_i),
        .cmd_sel_i   (cmd_sel_i),
        .cmd_adr_i   (cmd_adr_i),
        .cmd_dat_i   (cmd_dat_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_dat_o   (rsp_dat_o),
        .rsp_status_o(rsp_status_o),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_ack_i   (wbm_ack_i),
        .wbm_err_i   (wbm_err_i),
        .wbm_dat_i   (wbm_dat_i),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- clock ----------------
    always #5 wb_clk_i = ~wb_clk_i;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model: what the response must be for a given
    // slave behaviour. err (alone or with ack) -> ERR; ack -> OK with read
    // data for reads, zero for writes; silence -> TIMEOUT.
    function automatic logic [33:0] model_rsp(input logic we, input int kind, input logic [31:0] rd);
        case (kind)
            K_ACK:         return {2'b00, (we ? 32'h0 : rd)};
            K_ERR, K_BOTH: return {2'b01, 32'h0};
            default:       return {2'b10, 32'h0};
        endcase
    endfunction

    function automatic int model_stb_cycles(input int kind, input int waits);
        if (kind == K_NONE) return TIMEOUT;
        return waits + 1;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_wbm"}, {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o}, 64'h0);
        check({tag, "_rsp"}, {rsp_valid_o, rsp_status_o, rsp_dat_o}, 64'h0);
        check({tag, "_ready"}, cmd_ready_o, 1'b1);
        check({tag, "_state"}, dbg_state_o, 2'd0);
    endtask

    // ---------------- drivers ----------------
    task automatic drive_cmd(input int i);
        cmd_valid_i = 1'b1;
        cmd_we_i    = t_we[i];
        cmd_sel_i   = t_sel[i];
        cmd_adr_i   = t_adr[i];
        cmd_dat_i   = t_dat[i];
    endtask

    // Entered and left at a negative clock edge.
    task automatic run_txn(input int i);
        int guard;
        int stb_cycles;
        logic [33:0] exp;
        drive_cmd(i);
        guard = 0;
        while (!cmd_ready_o && guard < 50) begin
            @(negedge wb_clk_i);
            guard++;
        end
        if (!cmd_ready_o) begin
            check("accept_wait", 1'b0, 1'b1);
            cmd_valid_i = 1'b0;
            return;
        end
        exp_q.push_back(model_rsp(t_we[i], t_kind[i], t_rd[i]));
        @(posedge wb_clk_i);
        #1;
        if (t_chain[i] && (i + 1 < N_TXN)) drive_cmd(i + 1);
        else cmd_valid_i = 1'b0;

        stb_cycles = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge wb_clk_i);
            wbm_ack_i = 1'b0;
            wbm_err_i = 1'b0;
            wbm_dat_i = $urandom;
            if (rsp_valid_o) break;
            check("bus_ctl", {wbm_cyc_o, wbm_stb_o, wbm_we_o}, {2'b11, t_we[i]});
            check("bus_adr", wbm_adr_o, t_adr[i]);
            check("bus_sel_dat", {wbm_sel_o, wbm_dat_o}, {t_sel[i], t_dat[i]});
            check("ready_in_bus", cmd_ready_o, 1'b0);
            if (stb_cycles == t_waits[i] && t_kind[i] != K_NONE) begin
                wbm_ack_i = (t_kind[i] != K_ERR);
                wbm_err_i = (t_kind[i] != K_ACK);
                wbm_dat_i = t_rd[i];
            end
            stb_cycles++;
        end
        check("stb_cycles", stb_cycles, model_stb_cycles(t_kind[i], t_waits[i]));
        if (!rsp_valid_o) begin
            check("rsp_wait", 1'b0, 1'b1);
            void'(exp_q.pop_front());
            return;
        end
        check("bus_released", {wbm_cyc_o, wbm_stb_o}, 2'b00);
        exp = exp_q.pop_front();
        check("rsp", {rsp_status_o, rsp_dat_o}, exp);
        check("ready_in_resp", cmd_ready_o, 1'b0);

        // Backpressure, with stray slave strobes that must be ignored.
        for (int h = 0; h < t_hold[i]; h++) begin
            rsp_ready_i = 1'b0;
            wbm_ack_i   = $urandom_range(0, 1);
            wbm_err_i   = $urandom_range(0, 1);
            @(negedge wb_clk_i);
            wbm_ack_i = 1'b0;
            wbm_err_i = 1'b0;
            check("rsp_hold", {rsp_valid_o, rsp_status_o, rsp_dat_o}, {1'b1, exp});
            check("ready_hold", {cmd_ready_o, wbm_cyc_o, wbm_stb_o}, 3'b000);
        end
        rsp_ready_i = 1'b1;
        @(posedge wb_clk_i);
        #1;
        rsp_ready_i = 1'b0;
        @(negedge wb_clk_i);
        check("rsp_done", {rsp_valid_o, cmd_ready_o}, 2'b01);
        if (!cmd_valid_i) begin
            // Stray ack in IDLE must not start or finish anything.
            wbm_ack_i = 1'b1;
            @(negedge wb_clk_i);
            wbm_ack_i = 1'b0;
            check("idle_ack", {wbm_cyc_o, wbm_stb_o, rsp_valid_o, cmd_ready_o}, 4'b0001);
        end
    endtask

    task automatic set_txn(input int i, input logic we, input logic [3:0] sel, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [31:0] rd, input int waits,
                           input int kind, input int hold, input logic chain);
        t_we[i] = we; t_sel[i] = sel; t_adr[i] = adr; t_dat[i] = dat; t_rd[i] = rd;
        t_waits[i] = waits; t_kind[i] = kind; t_hold[i] = hold; t_chain[i] = chain;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        wb_rst_n_i  = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'b0;
        cmd_sel_i   = 4'h0;
        cmd_adr_i   = 32'h0;
        cmd_dat_i   = 32'h0;
        rsp_ready_i = 1'b0;
        wbm_ack_i   = 1'b0;
        wbm_err_i   = 1'b0;
        wbm_dat_i   = 32'h0;

        // Directed plan items.
        set_txn(0, 1'b1, 4'hF, 32'h3000_0004, 32'hDEAD_BEEF, 32'h0, 2, K_ACK, 0, 1'b0);
        set_txn(1, 1'b0, 4'hF, 32'h3000_0000, 32'h0, 32'h1234_5678, 0, K_ACK, 0, 1'b0);
        set_txn(2, 1'b0, 4'h3, 32'h3000_0008, 32'h0, 32'hCAFE_F00D, 1, K_BOTH, 1, 1'b0);
        set_txn(3, 1'b0, 4'hF, 32'h3000_0010, 32'h0, 32'hA5A5_5A5A, 1, K_ACK, 5, 1'b1);
        set_txn(4, 1'b1, 4'hC, 32'h3000_0014, 32'h0BAD_F00D, 32'h0, 0, K_ACK, 0, 1'b0);
`ifdef WB_MASTER_TIMEOUT_EN
        set_txn(5, 1'b0, 4'hF, 32'h3000_0020, 32'h0, 32'h1111_2222, 0, K_NONE, 0, 1'b0);
        set_txn(6, 1'b0, 4'hF, 32'h3000_0024, 32'h0, 32'h3333_4444, TIMEOUT - 1, K_ACK, 0, 1'b0);
`else
        set_txn(5, 1'b0, 4'h1, 32'h3000_0020, 32'h0, 32'h1111_2222, 6, K_ERR, 0, 1'b0);
        set_txn(6, 1'b1, 4'h8, 32'h3000_0024, 32'h5555_6666, 32'h3333_4444, 3, K_ACK, 2, 1'b0);
`endif
        for (int i = 7; i < N_TXN; i++) begin
`ifdef WB_MASTER_TIMEOUT_EN
            set_txn(i, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom, $urandom,
                    $urandom_range(0, TIMEOUT - 1), $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)));
`else
            set_txn(i, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom, $urandom,
                    $urandom_range(0, 6), $urandom_range(0, 2), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)));
`endif
        end

        repeat (3) @(negedge wb_clk_i);
        check_reset_vals("reset");
        wb_rst_n_i = 1'b1;
        @(negedge wb_clk_i);
        check_reset_vals("post_reset");

        for (int i = 0; i < N_TXN; i++) run_txn(i);
        cmd_valid_i = 1'b0;
        @(negedge wb_clk_i);

        // Reset in the middle of a bus cycle.
        drive_cmd(1);
        @(posedge wb_clk_i);
        #1;
        cmd_valid_i = 1'b0;
        repeat (2) @(negedge wb_clk_i);
        check("pre_rst_bus", {wbm_cyc_o, wbm_stb_o}, 2'b11);
        #2;
        wb_rst_n_i = 1'b0;
        #1;
        check("rst_async_drop", {wbm_cyc_o, wbm_stb_o}, 2'b00);
        check_reset_vals("mid_reset");
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hFFFF_0000;
        @(negedge wb_clk_i);
        wb_rst_n_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge wb_clk_i);
            check("late_ack_ignored", {rsp_valid_o, wbm_cyc_o, wbm_stb_o, cmd_ready_o}, 4'b0001);
        end
        wbm_ack_i = 1'b0;

        // Bridge still usable after the abort.
        run_txn(1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #500000;
        n_fail++;
        $display("FAIL global_timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
